// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and neighbour-count sizing for the Life controller
package life_pkg;
  typedef enum logic [2:0] {IDLE, FILL, ROW_WR, ROW_SHIFT, SWAP} state_t;
  localparam int NBR_N = 8;
  localparam int CNT_W = $clog2(NBR_N + 1);
endpackage

// File: rtl/life_gen_controller_if.sv
// life_gen_controller_if: control handshake plus ping-pong row-bank memory port
interface life_gen_controller_if #(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 32,
  parameter int GEN_W = 16
);
  localparam int AW = $clog2(HEIGHT);
  logic i_step;
  logic i_run;
  logic o_busy;
  logic o_done;
  logic o_front_bank;
  logic [GEN_W-1:0] o_gen_count;
  logic o_rd_en;
  logic o_rd_bank;
  logic [AW-1:0] o_rd_addr;
  logic [WIDTH-1:0] i_rd_data;
  logic o_wr_en;
  logic o_wr_bank;
  logic [AW-1:0] o_wr_addr;
  logic [WIDTH-1:0] o_wr_data;
  modport master (
    input i_step, i_run, i_rd_data,
    output o_busy, o_done, o_front_bank, o_gen_count, o_rd_en, o_rd_bank, o_rd_addr,
    output o_wr_en, o_wr_bank, o_wr_addr, o_wr_data
  );
  modport slave (
    output i_step, i_run, i_rd_data,
    input o_busy, o_done, o_front_bank, o_gen_count, o_rd_en, o_rd_bank, o_rd_addr,
    input o_wr_en, o_wr_bank, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/life_cell.sv
// life_cell: per-cell rule, survive on 2 or 3 live neighbours, birth on exactly 3
module life_cell
  import life_pkg::*;
(
  input  logic             alive,
  input  logic [NBR_N-1:0] nbr,
  output logic             next
);
  logic [CNT_W-1:0] cnt;
  // population count of the eight neighbours, then the survive/birth decision
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NBR_N; i++) cnt = cnt + CNT_W'(nbr[i]);
    next = (cnt == CNT_W'(3)) || (alive && cnt == CNT_W'(2));
  end
endmodule

// File: rtl/life_row_next.sv
// life_row_next: whole-row next generation with toroidal column wrap
module life_row_next #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] next_row
);
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int col_l = (c + WIDTH - 1) % WIDTH;
    localparam int col_r = (c + 1) % WIDTH;
    life_cell u_cell (
      .alive(cur[c]),
      .nbr  ({prev[col_l], prev[c], prev[col_r], cur[col_l], cur[col_r], nxt[col_l], nxt[c], nxt[col_r]}),
      .next (next_row[c])
    );
  end
endmodule

// File: rtl/life_gen_controller.sv
// life_gen_controller: sweeps the front bank through a 3-row window and writes the next generation to the back bank
module life_gen_controller
  import life_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 32,
  parameter int GEN_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  life_gen_controller_if.master bus
);
  localparam int AW = $clog2(HEIGHT);
  localparam logic [AW-1:0] LAST = AW'(HEIGHT - 1);
  localparam logic [AW-1:0] PENULT = AW'(HEIGHT - 2);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [AW-1:0] r_q, r_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, nxt_q, nxt_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic front_q, front_d, busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;

  life_row_next #(.WIDTH(WIDTH)) u_row (
    .prev    (prev_q),
    .cur     (cur_q),
    .nxt     (nxt_q),
    .next_row(bus.o_wr_data)
  );

  // next state, window shifting, and outputs decoded from the upcoming state so they leave a flop
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    prev_d = prev_q;
    cur_d = cur_q;
    nxt_d = nxt_q;
    front_d = front_q;
    gen_d = gen_q;
    case (state_q)
      IDLE: begin
        state_d = (bus.i_step || bus.i_run) ? FILL : IDLE;
        cnt_d = '0;
        r_d = '0;
      end
      FILL: begin
        prev_d = cnt_q == 2'd1 ? bus.i_rd_data : prev_q;
        cur_d = cnt_q == 2'd2 ? bus.i_rd_data : cur_q;
        nxt_d = cnt_q == 2'd3 ? bus.i_rd_data : nxt_q;
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? ROW_WR : FILL;
      end
      ROW_WR: state_d = r_q == LAST ? SWAP : ROW_SHIFT;
      ROW_SHIFT: begin
        prev_d = cur_q;
        cur_d = nxt_q;
        nxt_d = bus.i_rd_data;
        r_d = r_q + AW'(1);
        state_d = ROW_WR;
      end
      SWAP: begin
        front_d = ~front_q;
        gen_d = gen_q + GEN_W'(1);
        cnt_d = '0;
        r_d = '0;
        state_d = bus.i_run ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == SWAP;
    wr_en_d = state_d == ROW_WR;
    wr_addr_d = r_d;
    rd_en_d = (state_d == FILL && cnt_d != 2'd3) || (state_d == ROW_WR && r_d != LAST);
    rd_addr_d = state_d == FILL ? (cnt_d == 2'd0 ? LAST : AW'(cnt_d - 2'd1))
                                : (r_d == PENULT ? '0 : r_d + AW'(2));
  end

  // state and output registers, cleared asynchronously so a mid-sweep reset quiets the memory port at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      prev_q <= '0;
      cur_q <= '0;
      nxt_q <= '0;
      front_q <= 1'b0;
      gen_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      prev_q <= prev_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      front_q <= front_d;
      gen_q <= gen_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_front_bank = front_q;
  assign bus.o_gen_count = gen_q;
  assign bus.o_rd_en = rd_en_q;
  assign bus.o_rd_bank = front_q;
  assign bus.o_rd_addr = rd_addr_q;
  assign bus.o_wr_en = wr_en_q;
  assign bus.o_wr_bank = ~front_q;
  assign bus.o_wr_addr = wr_addr_q;
endmodule
